// File: rtl/keypad_emu_pkg.sv
// rtl/keypad_emu_pkg.sv - states, matrix constants and key decode shared by keypad_emulator
package keypad_emu_pkg;

    localparam int ROWS    = 4;
    localparam int COLS    = 3;
    localparam int KEY_NUM = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B_ON,
        ST_HOLD,
        ST_B_OFF,
        ST_GAP
    } emu_state_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } key_pos_t;

    // Codes are row*3 + col; only meaningful for codes below KEY_NUM.
    function automatic key_pos_t key_to_pos(input logic [3:0] key);
        key_pos_t p;
        p.row = 2'(key / 4'd3);
        p.col = 2'(key % 4'd3);
        return p;
    endfunction

endpackage

// File: rtl/emu_cycle_timer.sv
// rtl/emu_cycle_timer.sv - loadable down-counter, done while the count sits at zero
module emu_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x3 key matrix emulator with timed press/release commands
// Optional contact bounce on both edges: KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
    import keypad_emu_pkg::*;
#(
    parameter int HOLD_CYC   = 1000000,
    parameter int GAP_CYC    = 500000,
    parameter int BOUNCE_PER = 20000,
    parameter int BOUNCE_N   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      cmd_key,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [ROWS-1:0] scan_in,
    output logic [COLS-1:0] ret_out,
    output logic            key_down,
    output logic            busy,
    output logic            err_key
);

    localparam int MAX_HG = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int MAX_LD = (MAX_HG > BOUNCE_PER) ? MAX_HG : BOUNCE_PER;
`else
    localparam int MAX_LD = MAX_HG;
`endif
    localparam int TW = $clog2(MAX_LD - 1) + 1;
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int HALVES = 2 * BOUNCE_N;
    localparam int HW     = (HALVES > 1) ? $clog2(HALVES) : 1;
    localparam logic [TW-1:0] PER_LD    = TW'(BOUNCE_PER - 1);
    localparam logic [HW-1:0] LAST_HALF = HW'(HALVES - 1);
    logic [HW-1:0] r_half;
`endif

    emu_state_t  r_state;
    logic        r_contact;
    logic        r_err;
    logic [1:0]  r_row;
    logic [1:0]  r_col;
    logic        w_key_ok;
    logic        w_load;
    logic        w_done;
    logic [TW-1:0] w_load_val;
    key_pos_t    w_pos;

    assign w_key_ok = (cmd_key < 4'(KEY_NUM));
    assign w_pos    = key_to_pos(cmd_key);

    // The timer reloads on the same edge a phase ends, so phases abut with no idle cycle.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = HOLD_LD;
        case (r_state)
            ST_IDLE: if (cmd_valid && w_key_ok) begin
                w_load = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                w_load_val = PER_LD;
`else
                w_load_val = HOLD_LD;
`endif
            end
            ST_HOLD: if (w_done) begin
                w_load = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                w_load_val = PER_LD;
`else
                w_load_val = GAP_LD;
`endif
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            ST_B_ON: if (w_done) begin
                w_load     = 1'b1;
                w_load_val = (r_half == LAST_HALF) ? HOLD_LD : PER_LD;
            end
            ST_B_OFF: if (w_done) begin
                w_load     = 1'b1;
                w_load_val = (r_half == LAST_HALF) ? GAP_LD : PER_LD;
            end
`endif
            default: ;
        endcase
    end

    emu_cycle_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_done (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_contact <= 1'b0;
            r_err     <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            r_half    <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: if (cmd_valid) begin
                    if (w_key_ok) begin
                        r_row     <= w_pos.row;
                        r_col     <= w_pos.col;
                        r_contact <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        r_half    <= '0;
                        r_state   <= ST_B_ON;
`else
                        r_state   <= ST_HOLD;
`endif
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                ST_HOLD: if (w_done) begin
                    r_contact <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                    r_half    <= '0;
                    r_state   <= ST_B_OFF;
`else
                    r_state   <= ST_GAP;
`endif
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                ST_B_ON: if (w_done) begin
                    if (r_half == LAST_HALF) begin
                        r_contact <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else begin
                        r_half    <= r_half + 1'b1;
                        r_contact <= ~r_contact;
                    end
                end
                ST_B_OFF: if (w_done) begin
                    if (r_half == LAST_HALF) begin
                        r_contact <= 1'b0;
                        r_state   <= ST_GAP;
                    end else begin
                        r_half    <= r_half + 1'b1;
                        r_contact <= ~r_contact;
                    end
                end
`endif
                ST_GAP: if (w_done) begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sense path is combinational: a closed contact echoes its row's scan line immediately.
    always_comb begin
        ret_out = '0;
        for (int c = 0; c < COLS; c++) begin
            ret_out[c] = r_contact && (r_col == 2'(c)) && scan_in[r_row];
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign key_down  = r_contact;
    assign err_key   = r_err;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - scoreboard bench for keypad_emulator with an arithmetic timing model
module tb_keypad_emulator;

    localparam int H  = 8;
    localparam int G  = 4;
    localparam int P  = 2;
    localparam int BN = 2;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int BL = 2 * BN * P;
`else
    localparam int BL = 0;
`endif
    localparam int PRESS_LEN = 2 * BL + H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cmd_key = 4'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] scan_in = 4'd0;
    logic [2:0] ret_out;
    logic       key_down;
    logic       busy;
    logic       err_key;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_CYC   (H),
        .GAP_CYC    (G),
        .BOUNCE_PER (P),
        .BOUNCE_N   (BN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_key   (cmd_key),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .scan_in   (scan_in),
        .ret_out   (ret_out),
        .key_down  (key_down),
        .busy      (busy),
        .err_key   (err_key)
    );

    typedef struct {
        bit is_err;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   edge_n;
    int   free_edge;
    int   cur_start;
    int   cur_key;
    bit   accepted_now;
    bit   prev_busy;
    int   scan_mode;
    logic [3:0] scan_fix;
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, edge_n + 1, act, exp);
        end
    endtask

    // Contact level in cycle c, from the offset into the current press.
    function automatic bit model_contact(input int c);
        int o;
        o = c - cur_start;
        if (o < 0 || o >= PRESS_LEN) return 1'b0;
        if (o < BL) return ((o / P) % 2) == 0;
        if (o < BL + H) return 1'b1;
        return (((o - BL - H) / P) % 2) == 1;
    endfunction

    // Acceptance model: a command is taken at edge e if valid and the previous press has fully expired.
    always @(posedge clk) begin
        accepted_now = 1'b0;
        if (!rst) begin
            edge_n++;
            if (cmd_valid && edge_n >= free_edge) begin
                accepted_now = 1'b1;
                if (cmd_key > 4'd11) begin
                    sb_q.push_back('{1'b1, edge_n + 1});
                end else begin
                    sb_q.push_back('{1'b0, edge_n + 1});
                    cur_start = edge_n + 1;
                    cur_key   = int'(cmd_key);
                    free_edge = edge_n + 1 + PRESS_LEN + G;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        case (scan_mode)
            0: scan_in = 4'b0001 << (edge_n % 4);
            1: scan_in = ($urandom_range(0, 9) < 7) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            default: scan_in = scan_fix;
        endcase
    end

    // Monitor: per-cycle output checks plus scoreboard pops on press starts and error pulses.
    always @(negedge clk) begin
        int c;
        bit exp_kd;
        logic [2:0] exp_ret;
        exp_t e;
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            c = edge_n + 1;
            exp_kd = model_contact(c);
            exp_ret = (exp_kd && scan_in[cur_key / 3]) ? (3'b001 << (cur_key % 3)) : 3'b000;
            chk("key_down", key_down, exp_kd);
            chk("ret_out", ret_out, exp_ret);
            chk("cmd_ready", cmd_ready, c >= free_edge);
            chk("busy", busy, c < free_edge);
            if (key_down && !prev_busy) begin
                if (sb_q.size() == 0) chk("press_unexpected", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("press_kind", e.is_err, 0);
                    chk("press_cycle", c, e.cyc);
                end
            end
            if (err_key) begin
                if (sb_q.size() == 0) chk("err_unexpected", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    chk("err_kind", e.is_err, 1);
                    chk("err_cycle", c, e.cyc);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        tick();
        while (!accepted_now && n < 400) begin
            tick();
            n++;
        end
        if (!accepted_now) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 400) begin
            tick();
            n++;
        end
        chk("ready_timeout", cmd_ready, 1);
    endtask

    initial begin
        int first_edge;
        checks = 0; errors = 0;
        edge_n = 0; free_edge = 1; cur_start = -100000; cur_key = 0;
        scan_mode = 0; scan_fix = 4'd0; prev_busy = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_ret_out", ret_out, 3'b000);
        chk("rst_key_down", key_down, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_key", err_key, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;

        // Key 5 accepted at edge 10 with rotating one-hot scan.
        while (edge_n < 9) tick();
        cmd_valid = 1'b1; cmd_key = 4'd5;
        tick();
        chk("k5_accept_edge", edge_n, 10);
        cmd_valid = 1'b0; cmd_key = 4'd7;
        wait_ready();
        chk("k5_ready_edge", edge_n, 10 + PRESS_LEN + G);

        // Bad code, then an immediate good command on the following edge.
        cmd_valid = 1'b1; cmd_key = 4'd13;
        tick();
        chk("err_ready_held", cmd_ready, 1);
        cmd_key = 4'd0;
        tick();
        chk("after_err_accept", accepted_now, 1);
        first_edge = edge_n;
        cmd_key = 4'd11;
        wait_accept();
        chk("b2b_accept_edge", edge_n, first_edge + 1 + PRESS_LEN + G);
        cmd_valid = 1'b0;
        wait_ready();

        // Reset in the middle of a key-5 hold.
        scan_mode = 2; scan_fix = 4'b0010;
        cmd_valid = 1'b1; cmd_key = 4'd5;
        tick();
        cmd_valid = 1'b0;
        repeat (BL + 4) tick();
        chk("pre_rst_ret", ret_out, 3'b100);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ret", ret_out, 3'b000);
        chk("midrst_busy", busy, 0);
        chk("midrst_key_down", key_down, 0);
        sb_q.delete();
        edge_n = 0; free_edge = 1; cur_start = -100000;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk("post_rst_ready", cmd_ready, 1);

        // Two scan lines high while key 4 is held.
        scan_fix = 4'b0110;
        cmd_valid = 1'b1; cmd_key = 4'd4;
        tick();
        cmd_valid = 1'b0;
        repeat (BL + 3) tick();
        chk("multi_scan_ret", ret_out, 3'b010);
        wait_ready();

        // Random traffic; a zero gap keeps cmd_valid high for back-to-back acceptance.
        scan_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                cmd_valid = 1'b0;
                repeat (gap) tick();
            end
            cmd_valid = 1'b1;
            cmd_key = 4'($urandom_range(0, 15));
            wait_accept();
            cmd_key = 4'($urandom);
        end
        cmd_valid = 1'b0;
        wait_ready();
        repeat (3) tick();
        chk("sb_drain", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
